jtag_mode_scheduler: RTL and testbench

Arbitrates mode-change requests for the JTAG/PLD I/O mux from two requesters: the host command path and the on-board trigger unit. It drives the I/O mux's `mode_select`/`mode_input` handshake with the correct sequencing. Switching is bracketed by a hold window and a guard window so the JTAG lines stay frozen at their saved values across every transition. Each accepted request is acknowledged with a one-cycle pulse; a missing `mode_reset` response is reported as an error rather than hanging the controller.

---
 rtl/jtag_mode_scheduler.sv | 119 +++++++++++
 tb/tb_jtag_mode_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jtag_mode_scheduler.sv
// Round-robin arbiter that sequences JTAG/PLD I/O mux mode changes for the host
// and trigger requesters, bracketing each switch with hold and guard windows.
module jtag_mode_scheduler #(
   parameter int HOLD_CYCLES  = 4,
   parameter int GUARD_CYCLES = 2,
   parameter int TIMEOUT      = 16,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       host_req,
   input  logic [1:0] host_mode,
   input  logic       trig_req,
   input  logic [1:0] trig_mode,
   input  logic       mode_reset,
   output logic       mode_select,
   output logic [1:0] mode_input,
   output logic       host_ack,
   output logic       trig_ack,
   output logic       err,
   output logic       busy,
   output logic       grant_id
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ASSERT,
      S_HOLD,
      S_RELEASE,
      S_ACK
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             to_flag, to_flag_n;
   logic             grant_n;
   logic [1:0]       mode_n;

   // grant_id doubles as the round-robin pointer: it always names the last grantee.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      to_flag_n = to_flag;
      grant_n   = grant_id;
      mode_n    = mode_input;
      case (state)
         S_IDLE: begin
            if (host_req || trig_req) begin
               grant_n = (host_req && trig_req) ? ~grant_id : trig_req;
               mode_n  = grant_n ? trig_mode : host_mode;
               cnt_n   = '0;
               state_n = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (mode_reset) begin
               cnt_n   = '0;
               state_n = S_HOLD;
            end else if (cnt == TO_LAST) begin
               to_flag_n = 1'b1;
               cnt_n     = '0;
               state_n   = S_RELEASE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_n   = '0;
               state_n = S_RELEASE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RELEASE: begin
            if (cnt == GUARD_LAST) begin
               cnt_n   = '0;
               state_n = S_ACK;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_ACK: begin
            to_flag_n = 1'b0;
            state_n   = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         to_flag     <= 1'b0;
         grant_id    <= 1'b0;
         mode_input  <= 2'd0;
         mode_select <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         to_flag     <= to_flag_n;
         grant_id    <= grant_n;
         mode_input  <= mode_n;
         // Registered from next state so select tracks ASSERT/HOLD exactly.
         mode_select <= (state_n == S_ASSERT) || (state_n == S_HOLD);
      end
   end

   assign host_ack = (state == S_ACK) && !grant_id;
   assign trig_ack = (state == S_ACK) && grant_id;
   assign err      = (state == S_ACK) && to_flag;
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_jtag_mode_scheduler.sv
// Directed bench for jtag_mode_scheduler with a simple I/O mux responder model.
module tb_jtag_mode_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       host_req, trig_req, mode_reset;
   logic [1:0] host_mode, trig_mode;
   logic       mode_select, host_ack, trig_ack, err, busy, grant_id;
   logic [1:0] mode_input;

   int checks = 0;
   int errors = 0;

   // Mux model: raise mode_reset after three edges with mode_select high.
   logic mux_en;
   int   ms_cnt = 0;
   always @(posedge clk) ms_cnt <= mode_select ? ms_cnt + 1 : 0;
   assign mode_reset = mux_en && mode_select && (ms_cnt >= 3);

   jtag_mode_scheduler dut (
      .clk(clk), .reset(reset),
      .host_req(host_req), .host_mode(host_mode),
      .trig_req(trig_req), .trig_mode(trig_mode),
      .mode_reset(mode_reset), .mode_select(mode_select), .mode_input(mode_input),
      .host_ack(host_ack), .trig_ack(trig_ack), .err(err),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(host_ack || trig_ack) && cyc < 40);
   endtask

   int        cyc;
   int        seen;
   logic      exp_g [3];

   initial begin
      reset = 1'b1; host_req = 0; trig_req = 0; host_mode = 0; trig_mode = 0; mux_en = 1;
      tick(); tick();
      chk("rst mode_select", mode_select, 0);
      chk("rst mode_input", mode_input, 0);
      chk("rst acks", {host_ack, trig_ack}, 0);
      chk("rst err", err, 0);
      chk("rst busy", busy, 0);
      chk("rst grant_id", grant_id, 0);
      reset = 1'b0;

      // Host only: cycle 0 now
      host_req = 1; host_mode = 2;
      for (int c = 1; c <= 11; c++) begin
         tick();
         chk($sformatf("host c%0d mode_select", c), mode_select, (c <= 8));
         chk($sformatf("host c%0d mode_input", c), mode_input, 2);
         chk($sformatf("host c%0d host_ack", c), host_ack, (c == 11));
         chk($sformatf("host c%0d busy", c), busy, 1);
      end
      chk("host err", err, 0);
      host_req = 0;
      tick();
      chk("host idle busy", busy, 0);

      // Simultaneous requests after reset: trigger first
      reset = 1; tick(); reset = 0;
      host_req = 1; trig_req = 1; host_mode = 1; trig_mode = 3;
      tick();
      chk("tie1 grant_id", grant_id, 1);
      chk("tie1 mode_input", mode_input, 3);
      wait_ack(cyc);
      chk("tie1 ack cycle", cyc, 10);
      chk("tie1 trig_ack", trig_ack, 1);
      chk("tie1 host_ack", host_ack, 0);
      trig_req = 0;
      tick();
      chk("tie1 idle busy", busy, 0);
      tick();
      chk("tie2 grant_id", grant_id, 0);
      chk("tie2 mode_input", mode_input, 1);
      wait_ack(cyc);
      chk("tie2 ack cycle", cyc, 10);
      chk("tie2 host_ack", host_ack, 1);
      host_req = 0;

      // Repeated ties, back to back
      exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1;
      host_req = 1; trig_req = 1;
      for (int r = 0; r < 3; r++) begin
         tick(); tick();
         chk($sformatf("rr%0d grant_id", r), grant_id, exp_g[r]);
         wait_ack(cyc);
         chk($sformatf("rr%0d ack cycle", r), cyc, 10);
         chk($sformatf("rr%0d trig_ack", r), trig_ack, exp_g[r]);
      end
      host_req = 0; trig_req = 0;

      // No mux response -> timeout
      tick();
      host_req = 1; host_mode = 1; mux_en = 0;
      for (int c = 1; c <= 19; c++) begin
         tick();
         chk($sformatf("to c%0d mode_select", c), mode_select, (c <= 16));
         chk($sformatf("to c%0d host_ack", c), host_ack, (c == 19));
         chk($sformatf("to c%0d err", c), err, (c == 19));
      end
      host_req = 0; mux_en = 1;

      // Reset asserted in HOLD
      tick();
      host_req = 1; host_mode = 3;
      repeat (6) tick();
      chk("mid c6 mode_select", mode_select, 1);
      reset = 1;
      tick();
      reset = 0; host_req = 0;
      chk("mid c7 mode_select", mode_select, 0);
      chk("mid c7 busy", busy, 0);
      chk("mid c7 mode_input", mode_input, 0);
      seen = 0;
      repeat (15) begin
         tick();
         if (host_ack || trig_ack || err) seen++;
      end
      chk("mid no ack/err", seen, 0);
      host_req = 1; host_mode = 2;
      wait_ack(cyc);
      chk("recover ack cycle", cyc, 11);
      chk("recover host_ack", host_ack, 1);
      chk("recover err", err, 0);
      chk("recover mode_input", mode_input, 2);
      host_req = 0;

      // Mode change after grant is ignored
      tick();
      host_req = 1; host_mode = 0;
      tick();
      chk("mchg c1 mode_input", mode_input, 0);
      host_mode = 3;
      for (int c = 2; c <= 11; c++) begin
         tick();
         chk($sformatf("mchg c%0d mode_input", c), mode_input, 0);
      end
      chk("mchg host_ack", host_ack, 1);
      host_req = 0;
      tick();
      chk("final busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
